// File: rtl/slave_bus_master.sv
// rtl/slave_bus_master.sv - card-select slave bus initiator: one core request -> one bus cycle
//
// Turns a single valid/ready request from the core into a card-select bus
// cycle and returns a one-cycle response. Only one request is ever outstanding.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_wr/addr/wdata     request contents (1=write), 5-bit register index
//   AO/CARDSEL/WR_N/DO    registered bus outputs, AO = {SLAVE_PREFIX, 2'b00, addr}
//   SACK_N/DI             slave acknowledge (active low, one-cycle pulse) and read data
//   rsp_valid/rdata/err   one-cycle response strobe, read data, timeout flag
//   busy                  high whenever the FSM is not IDLE
//
// Optional feature: define SLAVE_BUS_MASTER_TIMEOUT_EN to abort a bus cycle
// with rsp_err=1 after TIMEOUT_CYCLES cycles without an acknowledge.

module slave_bus_master #(
  parameter logic [2:0] SLAVE_PREFIX   = 3'b011,
  parameter int         DATA_W         = 32,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [4:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [9:0]        AO,
  output logic              CARDSEL,
  output logic              WR_N,
  output logic [DATA_W-1:0] DO,
  input  logic              SACK_N,
  input  logic [DATA_W-1:0] DI,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // The slave edge detector needs at least two deselected cycles to re-arm.
  if (GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("slave_bus_master: GAP_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP, GAP} state_t;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t            state, state_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic [9:0]        ao_d;
  logic              cardsel_d, wr_n_d, rsp_valid_d;
  logic [DATA_W-1:0] do_d, rsp_rdata_d;

`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt, wait_cnt_d;
  logic            rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_d     = state;
    gap_cnt_d   = gap_cnt;
    ao_d        = AO;
    cardsel_d   = CARDSEL;
    wr_n_d      = WR_N;
    do_d        = DO;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt;
    rsp_err_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d   = ACTIVE;
          cardsel_d = 1'b1;
          ao_d      = {SLAVE_PREFIX, 2'b00, req_addr};
          wr_n_d    = ~req_wr;
          do_d      = req_wdata;
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      ACTIVE: begin
        // The ack is tested first so it wins over a timeout on the same edge.
        if (!SACK_N) begin
          state_d     = RESP;
          cardsel_d   = 1'b0;
          wr_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = WR_N ? DI : '0;
        end
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
        else if (wait_cnt == TO_W'(TIMEOUT_CYCLES)) begin
          state_d     = RESP;
          cardsel_d   = 1'b0;
          wr_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + TO_W'(1);
        end
`endif
      end
      RESP: begin
        state_d   = GAP;
        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      AO        <= '0;
      CARDSEL   <= 1'b0;
      WR_N      <= 1'b1;
      DO        <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      gap_cnt   <= gap_cnt_d;
      AO        <= ao_d;
      CARDSEL   <= cardsel_d;
      WR_N      <= wr_n_d;
      DO        <= do_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
      wait_cnt  <= wait_cnt_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_slave_bus_master.sv
// tb/tb_slave_bus_master.sv - randomized self-checking bench for slave_bus_master
module tb_slave_bus_master;

  localparam int DATA_W         = 32;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_wr;
  logic [4:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [9:0]        AO;
  logic              CARDSEL, WR_N;
  logic [DATA_W-1:0] DO;
  logic              SACK_N;
  logic [DATA_W-1:0] DI;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err, busy;

  slave_bus_master #(
    .SLAVE_PREFIX(3'b011), .DATA_W(DATA_W),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .AO(AO), .CARDSEL(CARDSEL), .WR_N(WR_N), .DO(DO),
    .SACK_N(SACK_N), .DI(DI),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: acks ack_delay cycles after it sees CARDSEL rise, once per cycle.
  logic              slave_en  = 1'b0;
  int                ack_delay = 1;
  logic [DATA_W-1:0] slave_di  = '0;
  logic              cs_prev   = 1'b0;
  bit                armed     = 1'b0;
  int                ack_cnt   = 0;
  int                n_acks    = 0;

  initial forever begin
    @(posedge clk); #1;
    if (slave_en) begin
      SACK_N = 1'b1;
      DI     = $urandom;
      if (CARDSEL && !cs_prev) begin
        armed   = 1'b1;
        ack_cnt = ack_delay;
      end else if (!CARDSEL) begin
        armed = 1'b0;
      end
      if (armed) begin
        if (ack_cnt == 0) begin
          SACK_N = 1'b0;
          DI     = slave_di;
          armed  = 1'b0;
          n_acks++;
        end else begin
          ack_cnt--;
        end
      end
    end
    cs_prev = CARDSEL;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] di);
    logic [9:0]  exp_ao;
    logic [31:0] exp_rd;
    logic        held_ok;
    int          cyc;
    exp_ao    = {3'b011, 2'b00, a};
    exp_rd    = wr ? 32'h0 : di;
    ack_delay = d;
    slave_di  = di;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = 5'($urandom); req_wdata = $urandom;
    check("cs_rise", CARDSEL, 1);
    check("ao", AO, exp_ao);
    check("wr_n", WR_N, !wr);
    check("do", DO, wd);
    check("busy", busy, 1);
    check("ready_low", req_ready, 0);
    held_ok = 1'b1;
    cyc = 0;
    while (!rsp_valid && cyc < 64) begin
      held_ok &= (CARDSEL === 1'b1) && (AO === exp_ao) && (DO === wd) && (WR_N === !wr);
      step();
      cyc++;
    end
    check("bus_hold", held_ok, 1);
    check("rsp_latency", cyc, d + 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, 0);
    check("cs_low_resp", CARDSEL, 0);
    check("wr_n_deselect", WR_N, 1);
    step();
    check("rsp_one_cycle", rsp_valid, 0);
    cyc = 1;
    while (!req_ready && cyc < 64) begin
      check("gap_cs_low", CARDSEL, 0);
      step();
      cyc++;
    end
    check("gap_len", cyc, GAP_CYCLES + 1);
  endtask

  initial begin
    int cyc, rises, low_run, gap_seen, rsps, acks0, seen_rsp;
    logic cs_last;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    SACK_N = 1'b1; DI = '0;
    repeat (3) step();
    check("rst_cardsel", CARDSEL, 0);
    check("rst_wr_n", WR_N, 1);
    check("rst_ao", AO, 0);
    check("rst_do", DO, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    reset = 1'b0;
    slave_en = 1'b1;
    step();

    run_txn(1'b0, 5'h0A, 32'h0, 1, 32'hDEADBEEF);
    run_txn(1'b1, 5'h03, 32'h12345678, 3, 32'hCAFEF00D);
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 6), $urandom);
      repeat ($urandom_range(0, 3)) step();
    end

    // Back-to-back: request held valid across two bus cycles.
    ack_delay = 1; slave_di = 32'hA5A5_0001;
    acks0 = n_acks; rises = 0; low_run = 0; gap_seen = -1; rsps = 0; cs_last = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'h11; req_wdata = '0;
    for (cyc = 0; cyc < 60 && rsps < 2; cyc++) begin
      step();
      if (rsp_valid) begin
        rsps++;
        if (rsps == 2) req_valid = 1'b0;
      end
      if (CARDSEL) begin
        if (!cs_last && rises > 0) gap_seen = low_run;
        if (!cs_last) rises++;
        low_run = 0;
      end else begin
        low_run++;
      end
      cs_last = CARDSEL;
    end
    check("b2b_rsps", rsps, 2);
    check("b2b_rises", rises, 2);
    check("b2b_gap", gap_seen, 2 + GAP_CYCLES);
    check("b2b_acks", n_acks - acks0, 2);
    for (cyc = 0; cyc < 64 && !req_ready; cyc++) step();
    check("b2b_idle", req_ready, 1);

    // Spurious acknowledge while idle.
    slave_en = 1'b0;
    step();
    SACK_N = 1'b0; DI = $urandom;
    step();
    SACK_N = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen_rsp++;
      step();
    end
    check("spur_no_rsp", seen_rsp, 0);
    check("spur_idle", busy, 0);
    check("spur_ready", req_ready, 1);

    // Reset two cycles into ACTIVE, followed by a late acknowledge.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'h07;
    step();
    req_valid = 1'b0;
    check("rmid_active", CARDSEL, 1);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmid_cs", CARDSEL, 0);
    check("rmid_busy", busy, 0);
    check("rmid_ready", req_ready, 1);
    check("rmid_rsp", rsp_valid, 0);
    seen_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      SACK_N = (i == 1) ? 1'b0 : 1'b1;
      if (rsp_valid) seen_rsp++;
      step();
    end
    SACK_N = 1'b1;
    check("rmid_no_rsp", seen_rsp, 0);

    // No acknowledge at all.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'h1F;
    step();
    req_valid = 1'b0;
`ifdef SLAVE_BUS_MASTER_TIMEOUT_EN
    cyc = 0;
    while (!rsp_valid && cyc < 64) begin
      step();
      cyc++;
    end
    check("to_latency", cyc, TIMEOUT_CYCLES + 1);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 0);
    for (cyc = 0; cyc < 64 && !req_ready; cyc++) step();
    check("to_idle", req_ready, 1);
`else
    seen_rsp = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) seen_rsp++;
      step();
    end
    check("hang_no_rsp", seen_rsp, 0);
    check("hang_busy", busy, 1);
    check("hang_cs", CARDSEL, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("hang_reset_idle", req_ready, 1);
`endif

    slave_en = 1'b1;
    step();
    run_txn(1'b0, 5'h15, 32'h0, 2, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
